// File: rtl/ttl_latch_ctrl_pkg.sv
// Shared types and default sizing for the latch-bank write sequencer.
package ttl_latch_ctrl_pkg;

    localparam int unsigned NREG_DEF = 8;
    localparam int unsigned DW_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        CLEAR   = 3'd4
    } state_t;

endpackage

// File: rtl/ttl_latch_bank_ctrl_if.sv
// Requester side and latch-bank side signals of the latch-bank controller.
interface ttl_latch_bank_ctrl_if #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 8
);
    localparam int unsigned AW = $clog2(NREG);

    logic [1:0]      req;
    logic [AW-1:0]   addr0;
    logic [AW-1:0]   addr1;
    logic [DW-1:0]   data0;
    logic [DW-1:0]   data1;
    logic [1:0]      ack;
    logic            clr_stb;
    logic [DW-1:0]   latch_d;
    logic [NREG-1:0] latch_cen;
    logic            latch_clrn;
    logic            busy;

    modport master (
        output req, addr0, addr1, data0, data1, clr_stb,
        input  ack, latch_d, latch_cen, latch_clrn, busy
    );

    modport slave (
        input  req, addr0, addr1, data0, data1, clr_stb,
        output ack, latch_d, latch_cen, latch_clrn, busy
    );
endinterface

// File: rtl/ttl_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the port not granted last.
module ttl_rr_arb2 (
    input  logic       Clk,
    input  logic       RESETn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_idx
);
    logic last_grant;

    assign grant_valid = |req;
    assign grant_idx   = (&req) ? ~last_grant : req[1];

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge Clk) begin
        if (!RESETn)
            last_grant <= 1'b1;
        else if (advance)
            last_grant <= grant_idx;
    end
endmodule

// File: rtl/ttl_latch_bank_ctrl.sv
// Write sequencer for a bank of 74273-style latches: arbitrates two byte
// writers and shapes each Cen strobe low-high-low around a one-cycle pulse.
module ttl_latch_bank_ctrl
    import ttl_latch_ctrl_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                  Clk,
    input  logic                  RESETn,
    ttl_latch_bank_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    state_t          state;
    logic [AW-1:0]   cap_addr;
    logic            cap_grant;
    logic            clr_pend;
    logic [1:0]      ack_q;
    logic [DW-1:0]   d_q;
    logic [NREG-1:0] cen_q;
    logic            clrn_q;
    logic            busy_q;

    logic            grant_valid;
    logic            grant_idx;
    logic            advance;

    assign advance = (state == IDLE) && !clr_pend && grant_valid;

    ttl_rr_arb2 u_arb (
        .Clk         (Clk),
        .RESETn      (RESETn),
        .req         (bus.req),
        .advance     (advance),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign bus.ack        = ack_q;
    assign bus.latch_d    = d_q;
    assign bus.latch_cen  = cen_q;
    assign bus.latch_clrn = clrn_q;
    assign bus.busy       = busy_q;

    // Sequencer; every output is set for the state being entered.
    always_ff @(posedge Clk) begin
        if (!RESETn) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_grant <= 1'b0;
            clr_pend  <= 1'b0;
            ack_q     <= '0;
            d_q       <= '0;
            cen_q     <= '0;
            clrn_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            ack_q  <= '0;
            cen_q  <= '0;
            clrn_q <= 1'b1;

            // A clear request arriving while in CLEAR merges into that clear.
            if (state == CLEAR)
                clr_pend <= 1'b0;
            else if (bus.clr_stb)
                clr_pend <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state  <= CLEAR;
                        clrn_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (grant_valid) begin
                        state     <= SETUP;
                        cap_grant <= grant_idx;
                        cap_addr  <= grant_idx ? bus.addr1 : bus.addr0;
                        d_q       <= grant_idx ? bus.data1 : bus.data0;
                        busy_q    <= 1'b1;
                    end else begin
                        busy_q <= bus.clr_stb;
                    end
                end
                SETUP: begin
                    state  <= STROBE;
                    cen_q  <= NREG'(1) << cap_addr;
                    busy_q <= 1'b1;
                end
                STROBE: begin
                    state  <= RELEASE;
                    ack_q  <= cap_grant ? 2'b10 : 2'b01;
                    busy_q <= 1'b1;
                end
                RELEASE: begin
                    state  <= IDLE;
                    busy_q <= clr_pend | bus.clr_stb;
                end
                CLEAR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ttl_latch_bank_ctrl.sv
// Directed bench for ttl_latch_bank_ctrl with a 74273-style latch bank model.
module tb_ttl_latch_bank_ctrl;
    import ttl_latch_ctrl_pkg::*;

    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 8;

    logic Clk    = 1'b0;
    logic RESETn = 1'b0;
    always #5 Clk = ~Clk;

    ttl_latch_bank_ctrl_if #(.NREG(NREG), .DW(DW)) bus ();

    ttl_latch_bank_ctrl #(.NREG(NREG), .DW(DW)) dut (
        .Clk    (Clk),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Latch bank model: CLRn has priority, capture on Cen rising edge.
    logic [DW-1:0]   mem [NREG] = '{default: '0};
    logic [NREG-1:0] last_cen = '1;
    int ack_cnt = 0;
    int clr_cnt = 0;
    int viol    = 0;

    always @(posedge Clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bus.latch_clrn === 1'b0)
                mem[i] <= '0;
            else if (bus.latch_cen[i] === 1'b1 && last_cen[i] === 1'b0)
                mem[i] <= bus.latch_d;
        end
        last_cen <= bus.latch_cen;
        if (bus.ack !== 2'b00 && RESETn) ack_cnt <= ack_cnt + 1;
        if (bus.latch_clrn === 1'b0) clr_cnt <= clr_cnt + 1;
        if (RESETn && ($countones(bus.latch_cen) > 1 ||
                       (bus.latch_cen !== '0 && last_cen !== '0)))
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        RESETn      = 1'b0;
        bus.req     = 2'b00;
        bus.clr_stb = 1'b0;
        step();
        step();
    endtask

    task automatic wait_ack(input string tag, input logic [1:0] exp, input int exp_n);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.ack == 2'b00 && n < 10);
        check({tag, "_ack"}, 32'(bus.ack), 32'(exp));
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
    endtask

    int base_ack;
    int base_clr;
    logic [DW-1:0] acc;

    initial begin
        bus.req   = 2'b00;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.data0 = '0;
        bus.data1 = '0;
        bus.clr_stb = 1'b0;

        // Reset state
        do_reset();
        check("rst_cen",  32'(bus.latch_cen), 32'h0);
        check("rst_ack",  32'(bus.ack), 32'h0);
        check("rst_d",    32'(bus.latch_d), 32'h0);
        check("rst_clrn", 32'(bus.latch_clrn), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        RESETn = 1'b1;

        // Single write, port 0, addr 3, data A5
        bus.req = 2'b01; bus.addr0 = 3'd3; bus.data0 = 8'hA5;
        step();
        check("w1_d_e0",    32'(bus.latch_d), 32'hA5);
        check("w1_cen_e0",  32'(bus.latch_cen), 32'h00);
        check("w1_busy_e0", 32'(bus.busy), 32'h1);
        step();
        check("w1_cen_e1",  32'(bus.latch_cen), 32'h08);
        check("w1_d_e1",    32'(bus.latch_d), 32'hA5);
        check("w1_ack_e1",  32'(bus.ack), 32'h0);
        step();
        check("w1_cen_e2",  32'(bus.latch_cen), 32'h00);
        check("w1_ack_e2",  32'(bus.ack), 32'h1);
        bus.req = 2'b00;
        step();
        check("w1_ack_e3",  32'(bus.ack), 32'h0);
        check("w1_busy_e3", 32'(bus.busy), 32'h0);
        check("w1_mem3",    32'(mem[3]), 32'hA5);

        // Both ports requesting continuously: alternate 0,1,0,1 at 4 cycles each
        do_reset();
        RESETn = 1'b1;
        bus.req = 2'b11;
        bus.addr0 = 3'd1; bus.data0 = 8'h11;
        bus.addr1 = 3'd2; bus.data1 = 8'h22;
        wait_ack("rr0", 2'b01, 3);
        wait_ack("rr1", 2'b10, 4);
        wait_ack("rr2", 2'b01, 4);
        wait_ack("rr3", 2'b10, 4);
        bus.req = 2'b00;
        step();
        check("rr_mem1", 32'(mem[1]), 32'h11);
        check("rr_mem2", 32'(mem[2]), 32'h22);
        check("rr_busy", 32'(bus.busy), 32'h0);

        // Clear requested during STROBE: write completes, then the bank clears
        base_clr = clr_cnt;
        bus.req = 2'b01; bus.addr0 = 3'd0; bus.data0 = 8'h5A;
        step();
        step();
        check("cs_cen", 32'(bus.latch_cen), 32'h01);
        bus.clr_stb = 1'b1;
        step();
        bus.clr_stb = 1'b0;
        check("cs_ack",  32'(bus.ack), 32'h1);
        check("cs_busy", 32'(bus.busy), 32'h1);
        bus.req = 2'b00;
        step();
        check("cs_mem0",  32'(mem[0]), 32'h5A);
        check("cs_clrn3", 32'(bus.latch_clrn), 32'h1);
        step();
        check("cs_clrn4", 32'(bus.latch_clrn), 32'h0);
        check("cs_busy4", 32'(bus.busy), 32'h1);
        step();
        check("cs_clrn5", 32'(bus.latch_clrn), 32'h1);
        check("cs_busy5", 32'(bus.busy), 32'h0);
        acc = '0;
        for (int i = 0; i < NREG; i++) acc |= mem[i];
        check("cs_all0",  32'(acc), 32'h0);
        check("cs_pulses", 32'(clr_cnt - base_clr), 32'h1);

        // Two clear strobes two cycles apart while busy merge into one clear
        base_clr = clr_cnt;
        base_ack = ack_cnt;
        bus.req = 2'b10; bus.addr1 = 3'd5; bus.data1 = 8'h77;
        step();
        bus.clr_stb = 1'b1;
        step();
        bus.clr_stb = 1'b0;
        step();
        bus.req = 2'b00;
        bus.clr_stb = 1'b1;
        step();
        bus.clr_stb = 1'b0;
        repeat (6) step();
        check("mc_pulses", 32'(clr_cnt - base_clr), 32'h1);
        check("mc_acks",   32'(ack_cnt - base_ack), 32'h1);
        check("mc_busy",   32'(bus.busy), 32'h0);
        check("mc_mem5",   32'(mem[5]), 32'h0);

        // Reset during STROBE abandons the write and the pending clear
        base_clr = clr_cnt;
        base_ack = ack_cnt;
        bus.req = 2'b01; bus.addr0 = 3'd6; bus.data0 = 8'hC3;
        step();
        bus.clr_stb = 1'b1;
        step();
        bus.clr_stb = 1'b0;
        check("rs_cen", 32'(bus.latch_cen), 32'h40);
        RESETn = 1'b0;
        bus.req = 2'b00;
        step();
        check("rs_cen0", 32'(bus.latch_cen), 32'h0);
        check("rs_ack",  32'(bus.ack), 32'h0);
        check("rs_clrn", 32'(bus.latch_clrn), 32'h1);
        check("rs_busy", 32'(bus.busy), 32'h0);
        RESETn = 1'b1;
        repeat (6) step();
        check("rs_no_ack", 32'(ack_cnt - base_ack), 32'h0);
        check("rs_no_clr", 32'(clr_cnt - base_clr), 32'h0);

        // Requester data changes during SETUP; captured value is used
        bus.req = 2'b01; bus.addr0 = 3'd4; bus.data0 = 8'h33;
        step();
        bus.data0 = 8'h44;
        step();
        step();
        check("dc_ack",  32'(bus.ack), 32'h1);
        check("dc_d",    32'(bus.latch_d), 32'h33);
        check("dc_mem4", 32'(mem[4]), 32'h33);
        bus.req = 2'b00;
        step();

        check("cen_shape", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ttl_latch_bank_ctrl.md
# ttl_latch_bank_ctrl

Write sequencer and two-port arbiter for a bank of octal edge-enabled latch registers (74273-style: synchronous CLRn with priority, capture on a rising edge of Cen). It takes byte writes from two synchronous requesters (e.g. main and sub CPU decode), arbitrates round-robin and drives shared D, one-hot Cen and a shared CLRn to the bank. Every Cen strobe is shaped low→high→low so each write produces exactly one detected rising edge.

## Interface
- NREG, 8: number of latch registers; power of two, ≥2; AW = $clog2(NREG)
- DW, 8: data width
- Clk  in  1  system clock; all logic on rising edge
- RESETn  in  1  synchronous, active-low reset
- req[1:0]  in  2  per-port write request; level, held until ack
- addr0, addr1  in  AW each  target latch index for port 0 / port 1
- data0, data1  in  DW each  write data for port 0 / port 1
- ack[1:0]  out  2  one-cycle completion pulse to the granted port
- clr_stb  in  1  one-cycle request to clear the whole bank
- latch_d  out  DW  shared data bus to all latches
- latch_cen  out  NREG  one-hot enable, one bit per latch
- latch_clrn  out  1  shared active-low clear to all latches
- busy  out  1  high whenever state ≠ IDLE or a clear is pending

## Operation
- States: IDLE, SETUP, STROBE, RELEASE, CLEAR.
- IDLE: if clr_pend, go CLEAR (clear beats writes). Else if any req: grant per arbiter, register grant/addr/data, go SETUP. Else stay.
- SETUP: latch_d = captured data, latch_cen all 0. Next STROBE.
- STROBE: latch_cen[addr] = 1, others 0; latch_d unchanged. Next RELEASE.
- RELEASE: latch_cen all 0; ack[grant] = 1 for this cycle. Next IDLE.
- CLEAR: latch_clrn = 0 for this one cycle, latch_cen all 0; clr_pend cleared. Next IDLE.
- clr_pend: set by clr_stb in any state, cleared only on leaving CLEAR; multiple clr_stb while pending merge into one clear.
- Arbiter: only one req → grant it. Both → grant the port not granted last; last_grant updates on each grant. After reset last_grant = 1, so port 0 wins the first tie.
- addr/data sampled only in IDLE on grant; later requester changes do not affect the in-flight write.
- All outputs registered; latch_cen at most one bit high, never high in two consecutive cycles.
- Reset values: state IDLE, ack 0, latch_cen 0, latch_d 0, latch_clrn 1, clr_pend 0, busy 0, last_grant 1.
- Reset mid-operation: sequence abandoned, no ack, no strobe; the pending clear is discarded.

## Timing
- Write, req seen at edge E0 in IDLE: latch_d valid after E0; latch_cen[addr] high E1–E2; latch captures at E2; ack high E2–E3; IDLE after E3.
- Minimum 4 cycles per write; back-to-back sustained rate one write per 4 cycles.
- Requester must drop or change req at the edge where it samples ack (E3); controller samples req again no earlier than E4, so no double write.
- Cen low ≥1 cycle before and after each strobe guarantees edge detection regardless of previous latch state (latch edge detector resets with last_cen = 1).
- Clear: clr_stb at edge Ec while IDLE → CLEAR after Ec+1, latch_clrn low Ec+1–Ec+2. clr_stb mid-write → clear runs after RELEASE; the in-flight write completes first, then is cleared.
- busy goes high the cycle after a grant or clr_stb, low in the first IDLE cycle with nothing pending.

## Structure
- Package ttl_latch_ctrl_pkg: state enum (IDLE, SETUP, STROBE, RELEASE, CLEAR), default NREG/DW constants.
- One sub-module: ttl_rr_arb2 (2-way round-robin; inputs req[1:0], advance; outputs grant_valid, grant_idx; owns last_grant).
- Top holds FSM, capture registers, clr_pend and output registers.

## Test plan
- Single write port 0, addr 3, data 0xA5 → latch_cen = 0x08 for exactly one cycle two edges after grant, latch_d = 0xA5 throughout, ack = 01 one cycle later; model latch 3 = 0xA5.
- Both req asserted continuously after reset, addr0 = 1/0x11, addr1 = 2/0x22 → grants alternate 0,1,0,1; each write 4 cycles; latches 1 and 2 hold correct data.
- clr_stb during STROBE of write 0x5A to latch 0 → write acks, then latch_clrn low one cycle; all model latches 0x00.
- Two clr_stb 2 cycles apart while busy → exactly one latch_clrn pulse.
- RESETn low during STROBE → next cycle latch_cen = 0, ack = 0, latch_clrn = 1, busy = 0; no ack ever issued for that request.
- Requester changes data0 from 0x33 to 0x44 during SETUP → latch captures 0x33.
